// File: rtl/vmem_pkg.sv
// vmem_pkg: shared widths, grant tags and block-engine states for the video-memory arbiter
package vmem_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int LEN_W = 16;
  typedef logic [ADDR_W-1:0] vmem_addr_t;
  typedef enum logic [1:0] {G_NONE, G_DISP, G_CPU, G_BLK} grant_t;
  typedef enum logic [2:0] {IDLE, LOAD, RD, WAIT, WR, DONE} blk_state_t;
endpackage

// File: rtl/vmem_blk_engine.sv
// vmem_blk_engine: block copy/fill sequencer issuing one RAM slot request at a time
module vmem_blk_engine
  import vmem_pkg::*;
(
  input  logic              clk_dot4x,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fill,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] val,
  output logic              req,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              gnt,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done
);
  blk_state_t state, state_d;
  vmem_addr_t src_q, dst_q;
  logic [LEN_W-1:0] len_q;
  logic fill_q;
  logic [DATA_W-1:0] val_q, byte_q;
  // operands travel with the one-cycle start pulse, so they are captured on that edge
  always_ff @(posedge clk_dot4x or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      fill_q <= 1'b0;
      val_q <= '0;
      byte_q <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) {src_q, dst_q, len_q, fill_q, val_q} <= {src, dst, len, fill, val};
      if (state == WAIT && rvalid) byte_q <= rdata;
      if (state == WR && gnt) begin
        src_q <= src_q + 1'b1;
        dst_q <= dst_q + 1'b1;
        len_q <= len_q - 1'b1;
      end
    end
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = start ? LOAD : IDLE;
      LOAD: state_d = len_q == '0 ? DONE : fill_q ? WR : RD;
      RD: state_d = gnt ? WAIT : RD;
      WAIT: state_d = rvalid ? WR : WAIT;
      WR: state_d = !gnt ? WR : len_q == LEN_W'(1) ? DONE : fill_q ? WR : RD;
      default: state_d = IDLE;
    endcase
  end
  assign req = state == RD || state == WR;
  assign req_we = state == WR;
  assign req_addr = state == WR ? dst_q : src_q;
  assign req_wdata = fill_q ? val_q : byte_q;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: shares one single-port video RAM between display fetch, CPU window and block engine
module vmem_arbiter
  import vmem_pkg::*;
(
  input  logic              clk_dot4x,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              blk_start,
  input  logic              blk_fill,
  input  logic [ADDR_W-1:0] blk_src,
  input  logic [ADDR_W-1:0] blk_dst,
  input  logic [LEN_W-1:0]  blk_len,
  input  logic [DATA_W-1:0] blk_val,
  output logic              blk_busy,
  output logic              blk_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  grant_t gnt, tag0, tag1;
  logic rr_cpu, cpu_we_q, blk_req, blk_we, rd_gnt;
  vmem_addr_t cpu_addr_q, blk_addr;
  logic [DATA_W-1:0] cpu_wdata_q, blk_wdata;
  vmem_blk_engine u_blk (
    .clk_dot4x, .rst_n, .start(blk_start), .fill(blk_fill), .src(blk_src), .dst(blk_dst),
    .len(blk_len), .val(blk_val), .req(blk_req), .req_we(blk_we), .req_addr(blk_addr),
    .req_wdata(blk_wdata), .gnt(gnt == G_BLK), .rvalid(tag1 == G_BLK), .rdata(ram_rdata),
    .busy(blk_busy), .done(blk_done)
  );
  // rr_cpu set means the CPU wins the next CPU/block tie
  assign gnt = disp_req ? G_DISP : (cpu_busy && blk_req) ? (rr_cpu ? G_CPU : G_BLK) :
               cpu_busy ? G_CPU : blk_req ? G_BLK : G_NONE;
  assign rd_gnt = gnt == G_DISP || (gnt == G_CPU && !cpu_we_q) || (gnt == G_BLK && !blk_we);
  always_ff @(posedge clk_dot4x or negedge rst_n)
    if (!rst_n) begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      tag0 <= G_NONE;
      tag1 <= G_NONE;
      disp_data <= '0;
      disp_valid <= 1'b0;
      cpu_rdata <= '0;
      cpu_rvalid <= 1'b0;
      cpu_busy <= 1'b0;
      cpu_we_q <= 1'b0;
      cpu_addr_q <= '0;
      cpu_wdata_q <= '0;
      rr_cpu <= 1'b1;
    end else begin
      ram_en <= gnt != G_NONE;
      ram_we <= gnt == G_CPU ? cpu_we_q : gnt == G_BLK && blk_we;
      ram_addr <= gnt == G_DISP ? disp_addr : gnt == G_CPU ? cpu_addr_q : blk_addr;
      ram_wdata <= gnt == G_CPU ? cpu_wdata_q : blk_wdata;
      tag0 <= rd_gnt ? gnt : G_NONE;
      tag1 <= tag0;
      disp_valid <= tag1 == G_DISP;
      cpu_rvalid <= tag1 == G_CPU;
      if (tag1 == G_DISP) disp_data <= ram_rdata;
      if (tag1 == G_CPU) cpu_rdata <= ram_rdata;
      rr_cpu <= gnt == G_CPU ? 1'b0 : gnt == G_BLK ? 1'b1 : rr_cpu;
      if (cpu_req && (!cpu_busy || gnt == G_CPU)) begin
        cpu_busy <= 1'b1;
        {cpu_we_q, cpu_addr_q, cpu_wdata_q} <= {cpu_we, cpu_addr, cpu_wdata};
      end else if (gnt == G_CPU) cpu_busy <= 1'b0;
    end
endmodule

// File: tb/tb_vmem_arbiter.sv
// tb_vmem_arbiter: self-checking bench for vmem_arbiter with a behavioural RAM and shadow memory model
`timescale 1ns/1ps
module tb_vmem_arbiter;
  logic clk_dot4x = 1'b0, rst_n = 1'b1;
  logic disp_req = 1'b0, disp_valid;
  logic [14:0] disp_addr = '0;
  logic [7:0] disp_data;
  logic cpu_req = 1'b0, cpu_we = 1'b0, cpu_busy, cpu_rvalid;
  logic [14:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0, cpu_rdata;
  logic blk_start = 1'b0, blk_fill = 1'b0, blk_busy, blk_done;
  logic [14:0] blk_src = '0, blk_dst = '0;
  logic [15:0] blk_len = '0;
  logic [7:0] blk_val = '0;
  logic ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata = '0;
  logic [7:0] mem [0:32767];
  logic [7:0] ref_mem [0:32767];
  int n_chk = 0, n_fail = 0;

  vmem_arbiter dut (
    .clk_dot4x(clk_dot4x), .rst_n(rst_n), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_valid(disp_valid), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .blk_start(blk_start), .blk_fill(blk_fill), .blk_src(blk_src),
    .blk_dst(blk_dst), .blk_len(blk_len), .blk_val(blk_val), .blk_busy(blk_busy),
    .blk_done(blk_done), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  always @(posedge clk_dot4x)
    if (ram_en) begin
      if (ram_we) mem[ram_addr] = ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_dot4x);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] all_out();
    return 64'({disp_data, disp_valid, cpu_busy, cpu_rdata, cpu_rvalid, blk_busy, blk_done,
                ram_en, ram_we, ram_addr, ram_wdata});
  endfunction

  task automatic run_blk(input logic fill, input logic [14:0] src, input logic [14:0] dst,
                         input logic [15:0] len, input logic [7:0] val,
                         output int done_cnt, output int en_cnt, output int first_done);
    blk_start = 1'b1; blk_fill = fill; blk_src = src; blk_dst = dst; blk_len = len; blk_val = val;
    done_cnt = 0; en_cnt = 0; first_done = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      blk_start = 1'b0;
      if (k == 1) chk("blk_busy after start", 64'(blk_busy), 64'd1);
      if (blk_done) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
      end
      if (ram_en) en_cnt++;
    end
  endtask

  typedef struct {
    bit cpu;
    bit we;
    logic [14:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];
  logic [7:0] exp_disp [$];
  logic [7:0] exp_cpu [$];
  logic [14:0] exp_addr [10];

  initial begin
    int run, busy_run, max_busy, dc, ec, fd;
    logic [7:0] old_a, old_b;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    #2 rst_n = 1'b0;
    #1 chk("reset outputs", all_out(), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    chk("reset outputs held", all_out(), 64'd0);

    // random CPU/display traffic against the shadow memory; display reads upper half only
    run = 0; busy_run = 0; max_busy = 0;
    for (int c = 0; c < 3000; c++) begin
      disp_req = run < 3 && $urandom_range(0, 1) == 1;
      run = disp_req ? run + 1 : 0;
      if (disp_req) begin
        disp_addr = 15'h4000 | 15'($urandom_range(0, 16383));
        exp_disp.push_back(ref_mem[disp_addr]);
      end
      cpu_req = 1'b0;
      if (!cpu_busy && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1;
        cpu_we = $urandom_range(0, 1) == 1;
        cpu_addr = cpu_we ? 15'($urandom_range(0, 16383)) : 15'($urandom_range(0, 32767));
        cpu_wdata = 8'($urandom);
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        else exp_cpu.push_back(ref_mem[cpu_addr]);
      end
      tick();
      if (disp_valid) begin
        if (exp_disp.size() == 0) chk("rand disp_valid spurious", 64'd1, 64'd0);
        else chk("rand disp_data", 64'(disp_data), 64'(exp_disp.pop_front()));
      end
      if (cpu_rvalid) begin
        if (exp_cpu.size() == 0) chk("rand cpu_rvalid spurious", 64'd1, 64'd0);
        else chk("rand cpu_rdata", 64'(cpu_rdata), 64'(exp_cpu.pop_front()));
      end
      busy_run = cpu_busy ? busy_run + 1 : 0;
      if (busy_run > max_busy) max_busy = busy_run;
    end
    disp_req = 1'b0; cpu_req = 1'b0;
    repeat (4) begin
      tick();
      if (disp_valid && exp_disp.size() > 0) chk("rand disp_data tail", 64'(disp_data), 64'(exp_disp.pop_front()));
      if (cpu_rvalid && exp_cpu.size() > 0) chk("rand cpu_rdata tail", 64'(cpu_rdata), 64'(exp_cpu.pop_front()));
    end
    chk("rand disp reads outstanding", 64'(exp_disp.size()), 64'd0);
    chk("rand cpu reads outstanding", 64'(exp_cpu.size()), 64'd0);
    chk("rand cpu latency within 8", 64'(max_busy <= 8), 64'd1);

    vecs[0] = '{cpu: 1'b0, we: 1'b0, addr: 15'h0100, data: 8'h5A, exp: 8'h5A};
    vecs[1] = '{cpu: 1'b1, we: 1'b1, addr: 15'h7FFF, data: 8'h3C, exp: 8'h00};
    vecs[2] = '{cpu: 1'b1, we: 1'b0, addr: 15'h7FFF, data: 8'h00, exp: 8'h3C};
    vecs[3] = '{cpu: 1'b1, we: 1'b1, addr: 15'h0000, data: 8'hC3, exp: 8'h00};
    vecs[4] = '{cpu: 1'b1, we: 1'b0, addr: 15'h0000, data: 8'h00, exp: 8'hC3};
    vecs[5] = '{cpu: 1'b0, we: 1'b0, addr: 15'h7FFF, data: 8'hA7, exp: 8'hA7};
    vecs[6] = '{cpu: 1'b1, we: 1'b0, addr: 15'h7FFF, data: 8'h00, exp: 8'hA7};
    vecs[7] = '{cpu: 1'b0, we: 1'b0, addr: 15'h2AAA, data: 8'h00, exp: 8'h00};
    foreach (vecs[i]) begin
      if (!vecs[i].cpu) begin
        mem[vecs[i].addr] = vecs[i].data;
        disp_req = 1'b1; disp_addr = vecs[i].addr;
        tick();
        disp_req = 1'b0;
        chk("disp slot", 64'({ram_en, ram_we, ram_addr}), 64'({2'b10, vecs[i].addr}));
        tick(); chk("disp_valid early", 64'(disp_valid), 64'd0);
        tick(); chk("disp_valid at 2", 64'(disp_valid), 64'd1);
        chk("disp_data", 64'(disp_data), 64'(vecs[i].exp));
        tick(); chk("disp_valid pulse", 64'(disp_valid), 64'd0);
      end else begin
        cpu_req = 1'b1; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].data;
        tick();
        cpu_req = 1'b0;
        chk("cpu_busy set", 64'(cpu_busy), 64'd1);
        tick();
        chk("cpu_busy clear", 64'(cpu_busy), 64'd0);
        chk("cpu slot", 64'({ram_en, ram_we, ram_addr, ram_wdata}),
            64'({1'b1, vecs[i].we, vecs[i].addr, vecs[i].data}));
        tick(); chk("cpu_rvalid early", 64'(cpu_rvalid), 64'd0);
        tick();
        if (vecs[i].we) chk("cpu write landed", 64'(mem[vecs[i].addr]), 64'(vecs[i].data));
        else begin
          chk("cpu_rvalid at 2", 64'(cpu_rvalid), 64'd1);
          chk("cpu_rdata", 64'(cpu_rdata), 64'(vecs[i].exp));
        end
        tick(); chk("cpu_rvalid idle", 64'(cpu_rvalid), 64'd0);
      end
    end

    // contention: display holds three slots, then CPU and fill alternate starting with CPU
    do_reset();
    old_a = mem[15'h05FF];
    exp_addr = '{15'h0100, 15'h0100, 15'h0100, 15'h0500, 15'h0300,
                 15'h0501, 15'h0301, 15'h0502, 15'h0302, 15'h0303};
    disp_req = 1'b1; disp_addr = 15'h0100;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0500; cpu_wdata = 8'h50;
    blk_start = 1'b1; blk_fill = 1'b1; blk_src = '0; blk_dst = 15'h0300; blk_len = 16'd4; blk_val = 8'h77;
    for (int e = 0; e < 10; e++) begin
      tick();
      blk_start = 1'b0; cpu_req = 1'b0;
      if (e == 0) begin cpu_req = 1'b1; cpu_addr = 15'h05FF; cpu_wdata = 8'hFF; end
      if (e == 2) begin cpu_req = 1'b1; cpu_addr = 15'h0501; cpu_wdata = 8'h51; disp_req = 1'b0; end
      if (e == 4) begin cpu_req = 1'b1; cpu_addr = 15'h0502; cpu_wdata = 8'h52; end
      chk($sformatf("contention slot %0d", e), 64'({ram_en, ram_addr}), 64'({1'b1, exp_addr[e]}));
    end
    chk("contention blk_done", 64'(blk_done), 64'd1);
    tick();
    chk("contention idle", 64'({blk_done, blk_busy, ram_en, cpu_busy}), 64'd0);
    chk("contention cpu data", 64'({mem[15'h0500], mem[15'h0501], mem[15'h0502]}), 64'h505152);
    chk("dropped cpu_req", 64'(mem[15'h05FF]), 64'(old_a));
    chk("contention fill", 64'({mem[15'h0300], mem[15'h0301], mem[15'h0302], mem[15'h0303]}), 64'h77777777);

    old_a = mem[15'h0002];
    run_blk(1'b1, 15'h0000, 15'h7FFE, 16'd4, 8'hEE, dc, ec, fd);
    chk("fill done once", 64'(dc), 64'd1);
    chk("fill done cycle", 64'(fd), 64'd6);
    chk("fill ram slots", 64'(ec), 64'd4);
    chk("fill busy clear", 64'(blk_busy), 64'd0);
    chk("fill wrap data", 64'({mem[15'h7FFE], mem[15'h7FFF], mem[15'h0000], mem[15'h0001]}), 64'hEEEEEEEE);
    chk("fill stops at len", 64'(mem[15'h0002]), 64'(old_a));

    mem[15'h0010] = 8'h11; mem[15'h0011] = 8'h22; mem[15'h0012] = 8'h33;
    run_blk(1'b0, 15'h0010, 15'h0200, 16'd3, 8'h00, dc, ec, fd);
    chk("copy done once", 64'(dc), 64'd1);
    chk("copy ram slots", 64'(ec), 64'd6);
    chk("copy data", 64'({mem[15'h0200], mem[15'h0201], mem[15'h0202]}), 64'h112233);
    run_blk(1'b0, 15'h0010, 15'h0200, 16'd0, 8'h00, dc, ec, fd);
    chk("len0 done once", 64'(dc), 64'd1);
    chk("len0 done cycle", 64'(fd), 64'd2);
    chk("len0 no ram access", 64'(ec), 64'd0);

    // reset while the copy waits for its first read byte
    old_b = mem[15'h0400];
    blk_start = 1'b1; blk_fill = 1'b0; blk_src = 15'h0010; blk_dst = 15'h0400; blk_len = 16'd3;
    tick();
    blk_start = 1'b0;
    tick(); tick();
    chk("copy read issued", 64'({ram_en, ram_we, ram_addr}), 64'({2'b10, 15'h0010}));
    #2 rst_n = 1'b0;
    #1 chk("mid-op reset outputs", all_out(), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    dc = 0; ec = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (blk_done || disp_valid || cpu_rvalid) dc++;
      if (ram_en) ec++;
    end
    chk("no pulses after reset", 64'(dc), 64'd0);
    chk("no ram access after reset", 64'(ec), 64'd0);
    chk("aborted copy wrote nothing", 64'(mem[15'h0400]), 64'(old_b));
    run_blk(1'b1, 15'h0000, 15'h0600, 16'd2, 8'h9C, dc, ec, fd);
    chk("post-reset fill done", 64'(dc), 64'd1);
    chk("post-reset fill data", 64'({mem[15'h0600], mem[15'h0601]}), 64'h9C9C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
